// File: rtl/aqed_multi_check.sv
// A-QED self-consistency monitor: pairs each original write with a duplicate that
// replays the captured payload, matches responses by sequence index and compares them.
module aqed_multi_check #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32,
    parameter int NPAIRS = 4,
    localparam int IDX_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic                flush,
    input  logic                exec_dup,
    input  logic                wen_in,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    input  logic                valid_out,
    input  logic [DATA_W-1:0]   data_out_in,
    output logic                qed_done,
    output logic                qed_check,
    output logic [IDX_W-1:0]    fail_idx,
    output logic [CNT_W-1:0]    dbg_in_count,
    output logic [CNT_W-1:0]    dbg_out_count,
    output logic [IDX_W:0]      dbg_ptr,
    output logic [2*NPAIRS-1:0] dbg_pair_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ORIG = 2'd1;
    localparam logic [1:0] S_DUP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W:0]   PTR_END = (IDX_W + 1)'(NPAIRS);

    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic [IDX_W:0]    ptr;

    logic [1:0]        state     [NPAIRS];
    logic [DATA_W-1:0] orig_data [NPAIRS];
    logic [CNT_W-1:0]  orig_idx  [NPAIRS];
    logic [CNT_W-1:0]  dup_idx   [NPAIRS];
    logic [DATA_W-1:0] orig_resp [NPAIRS];
    logic [DATA_W-1:0] dup_resp  [NPAIRS];
    logic [NPAIRS-1:0] orig_got;
    logic [NPAIRS-1:0] dup_got;

    logic              acc;
    logic              ptr_ok;
    logic [NPAIRS-1:0] sel;
    logic [1:0]        cur_state;
    logic [DATA_W-1:0] cur_data;
    logic              issue_orig;
    logic              issue_dup;
    logic [NPAIRS-1:0] hit_orig;
    logic [NPAIRS-1:0] hit_dup;
    logic [NPAIRS-1:0] done_now;
    logic              fail_any;
    logic [IDX_W-1:0]  fail_k;
    logic              any_busy;
    logic              any_done;

    // in_count stops at all-ones so the sentinel index can never be issued
    assign acc    = reset_n & clk_en & wen_in & ~flush & (in_count != CNT_MAX);
    assign ptr_ok = (ptr < PTR_END);

    always_comb begin
        sel       = '0;
        cur_state = S_IDLE;
        cur_data  = '0;
        for (int k = 0; k < NPAIRS; k++) begin
            sel[k] = ptr_ok && (ptr[IDX_W-1:0] == IDX_W'(k));
            if (sel[k]) begin
                cur_state = state[k];
                cur_data  = orig_data[k];
            end
        end
    end

    assign issue_orig = acc & exec_dup & ptr_ok & (cur_state == S_IDLE);
    assign issue_dup  = acc & exec_dup & ptr_ok & (cur_state == S_ORIG);
    assign data_out   = issue_dup ? cur_data : data_in;

    always_comb begin
        hit_orig = '0;
        hit_dup  = '0;
        done_now = '0;
        fail_any = 1'b0;
        fail_k   = '0;
        any_busy = 1'b0;
        any_done = 1'b0;
        // descending scan so the lowest failing pair index is the one kept
        for (int k = NPAIRS - 1; k >= 0; k--) begin
            hit_orig[k] = valid_out && (out_count == orig_idx[k]) && (state[k] != S_IDLE);
            hit_dup[k]  = valid_out && !hit_orig[k] && (out_count == dup_idx[k])
                          && (state[k] == S_DUP);
            done_now[k] = (state[k] == S_DUP) && orig_got[k] && dup_got[k];
            if (done_now[k] && (orig_resp[k] != dup_resp[k])) begin
                fail_any = 1'b1;
                fail_k   = IDX_W'(k);
            end
            if ((state[k] == S_ORIG) || (state[k] == S_DUP)) any_busy = 1'b1;
            if (state[k] == S_DONE) any_done = 1'b1;
        end
    end

    assign qed_done = ~any_busy & any_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_count  <= '0;
            out_count <= '0;
            ptr       <= '0;
            qed_check <= 1'b1;
            fail_idx  <= '0;
            orig_got  <= '0;
            dup_got   <= '0;
            for (int k = 0; k < NPAIRS; k++) begin
                state[k]     <= S_IDLE;
                orig_data[k] <= '0;
                orig_idx[k]  <= CNT_MAX;
                dup_idx[k]   <= CNT_MAX;
                orig_resp[k] <= '0;
                dup_resp[k]  <= '0;
            end
        end else if (clk_en) begin
            if (acc)       in_count  <= in_count + 1'b1;
            if (valid_out) out_count <= out_count + 1'b1;
            if (issue_dup) ptr       <= ptr + 1'b1;
            for (int k = 0; k < NPAIRS; k++) begin
                if (issue_orig && sel[k]) begin
                    orig_data[k] <= data_in;
                    orig_idx[k]  <= in_count;
                    state[k]     <= S_ORIG;
                end
                if (issue_dup && sel[k]) begin
                    dup_idx[k] <= in_count;
                    state[k]   <= S_DUP;
                end
                if (hit_orig[k]) begin
                    orig_resp[k] <= data_out_in;
                    orig_got[k]  <= 1'b1;
                end
                if (hit_dup[k]) begin
                    dup_resp[k] <= data_out_in;
                    dup_got[k]  <= 1'b1;
                end
                if (done_now[k]) state[k] <= S_DONE;
            end
            if (fail_any && qed_check) begin
                qed_check <= 1'b0;
                fail_idx  <= fail_k;
            end
        end
    end

    assign dbg_in_count  = in_count;
    assign dbg_out_count = out_count;
    assign dbg_ptr       = ptr;
    always_comb begin
        dbg_pair_state = '0;
        for (int k = 0; k < NPAIRS; k++) dbg_pair_state[2*k +: 2] = state[k];
    end

endmodule

// File: tb/tb_aqed_multi_check.sv
// Directed bench for aqed_multi_check: a vector table for the single-pair flows plus
// hand-written sequences for multi-pair, flush/enable, saturation and mid-pair reset.
module tb_aqed_multi_check;

    logic        clk = 1'b0;
    logic        reset_n, clk_en, flush, exec_dup, wen_in, valid_out;
    logic [15:0] data_in, data_out_in;
    logic [15:0] data_out;
    logic        qed_done, qed_check;
    logic [1:0]  fail_idx;
    logic [31:0] dbg_in_count, dbg_out_count;
    logic [2:0]  dbg_ptr;
    logic [7:0]  dbg_pair_state;

    logic [15:0] s_data_out;
    logic        s_qed_done, s_qed_check;
    logic [1:0]  s_fail_idx;
    logic [3:0]  s_in_count, s_out_count;
    logic [2:0]  s_ptr;
    logic [7:0]  s_pair_state;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aqed_multi_check #(.DATA_W(16), .CNT_W(32), .NPAIRS(4)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
        .exec_dup(exec_dup), .wen_in(wen_in), .data_in(data_in), .data_out(data_out),
        .valid_out(valid_out), .data_out_in(data_out_in), .qed_done(qed_done),
        .qed_check(qed_check), .fail_idx(fail_idx), .dbg_in_count(dbg_in_count),
        .dbg_out_count(dbg_out_count), .dbg_ptr(dbg_ptr), .dbg_pair_state(dbg_pair_state)
    );

    aqed_multi_check #(.DATA_W(16), .CNT_W(4), .NPAIRS(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
        .exec_dup(exec_dup), .wen_in(wen_in), .data_in(data_in), .data_out(s_data_out),
        .valid_out(valid_out), .data_out_in(data_out_in), .qed_done(s_qed_done),
        .qed_check(s_qed_check), .fail_idx(s_fail_idx), .dbg_in_count(s_in_count),
        .dbg_out_count(s_out_count), .dbg_ptr(s_ptr), .dbg_pair_state(s_pair_state)
    );

    typedef struct {
        logic        rst_n, en, fl, wen, ed;
        logic [15:0] din;
        logic        vo;
        logic [15:0] rsp;
        logic [15:0] e_dout;
        logic [31:0] e_cnt;
        logic [2:0]  e_ptr;
        logic        e_done, e_chk;
        logic [1:0]  e_fidx;
    } vec_t;

    vec_t vecs[18];
    logic [15:0] exp_q[$];

    function automatic vec_t mk(logic rst_n, logic wen, logic ed, logic [15:0] din,
                                logic vo, logic [15:0] rsp, logic [15:0] e_dout,
                                logic [31:0] e_cnt, logic [2:0] e_ptr, logic e_done,
                                logic e_chk, logic [1:0] e_fidx);
        vec_t v;
        v.rst_n = rst_n; v.en = 1'b1; v.fl = 1'b0; v.wen = wen; v.ed = ed; v.din = din;
        v.vo = vo; v.rsp = rsp; v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_ptr = e_ptr;
        v.e_done = e_done; v.e_chk = e_chk; v.e_fidx = e_fidx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rst_n, input logic en, input logic fl, input logic wen,
                          input logic ed, input logic [15:0] din, input logic vo,
                          input logic [15:0] rsp);
        reset_n = rst_n; clk_en = en; flush = fl; wen_in = wen; exec_dup = ed;
        data_in = din; valid_out = vo; data_out_in = rsp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, check the combinational forward before the edge.
    task automatic cyc(input logic rst_n, input logic en, input logic fl, input logic wen,
                       input logic ed, input logic [15:0] din, input logic vo,
                       input logic [15:0] rsp, input string name, input logic [15:0] e_dout);
        set_in(rst_n, en, fl, wen, ed, din, vo, rsp);
        #3;
        check({name, " dout"}, 32'(data_out), 32'(e_dout));
        tick();
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        tick();
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        tick();

        //            rst wen ed  din      vo  rsp      dout     cnt ptr done chk fidx
        vecs[0]  = mk(0,  0,  0,  16'h0,   0,  16'h0,   16'h0,    0, 0,  0,  1,  0);
        vecs[1]  = mk(1,  1,  1,  16'h1234,0,  16'h0,   16'h1234, 1, 0,  0,  1,  0);
        vecs[2]  = mk(1,  1,  0,  16'h0001,1,  16'h1234,16'h0001, 2, 0,  0,  1,  0);
        vecs[3]  = mk(1,  1,  0,  16'h0002,1,  16'h0001,16'h0002, 3, 0,  0,  1,  0);
        vecs[4]  = mk(1,  1,  1,  16'hFFFF,1,  16'h0002,16'h1234, 4, 1,  0,  1,  0);
        vecs[5]  = mk(1,  0,  0,  16'h0,   1,  16'h1234,16'h0,    4, 1,  0,  1,  0);
        vecs[6]  = mk(1,  0,  0,  16'h0,   0,  16'h0,   16'h0,    4, 1,  1,  1,  0);
        vecs[7]  = mk(0,  0,  0,  16'h0,   0,  16'h0,   16'h0,    0, 0,  0,  1,  0);
        vecs[8]  = mk(1,  1,  1,  16'h1234,0,  16'h0,   16'h1234, 1, 0,  0,  1,  0);
        vecs[9]  = mk(1,  1,  0,  16'h0001,1,  16'h1234,16'h0001, 2, 0,  0,  1,  0);
        vecs[10] = mk(1,  1,  0,  16'h0002,1,  16'h0001,16'h0002, 3, 0,  0,  1,  0);
        vecs[11] = mk(1,  1,  1,  16'hFFFF,1,  16'h0002,16'h1234, 4, 1,  0,  1,  0);
        vecs[12] = mk(1,  0,  0,  16'h0,   1,  16'hBEEF,16'h0,    4, 1,  0,  1,  0);
        vecs[13] = mk(1,  0,  0,  16'h0,   0,  16'h0,   16'h0,    4, 1,  1,  0,  0);
        vecs[14] = mk(1,  1,  1,  16'hABCD,0,  16'h0,   16'hABCD, 5, 1,  0,  0,  0);
        vecs[15] = mk(1,  1,  1,  16'h5555,1,  16'hABCD,16'hABCD, 6, 2,  0,  0,  0);
        vecs[16] = mk(1,  0,  0,  16'h0,   1,  16'hABCD,16'h0,    6, 2,  0,  0,  0);
        vecs[17] = mk(1,  0,  0,  16'h0,   0,  16'h0,   16'h0,    6, 2,  1,  0,  0);

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].rst_n, vecs[i].en, vecs[i].fl, vecs[i].wen, vecs[i].ed, vecs[i].din,
                vecs[i].vo, vecs[i].rsp, $sformatf("row%0d", i), vecs[i].e_dout);
            check($sformatf("row%0d in_count", i), dbg_in_count, vecs[i].e_cnt);
            check($sformatf("row%0d ptr", i), 32'(dbg_ptr), 32'(vecs[i].e_ptr));
            check($sformatf("row%0d qed_done", i), 32'(qed_done), 32'(vecs[i].e_done));
            check($sformatf("row%0d qed_check", i), 32'(qed_check), 32'(vecs[i].e_chk));
            check($sformatf("row%0d fail_idx", i), 32'(fail_idx), 32'(vecs[i].e_fidx));
        end

        // Five orig/dup issue pairs on a 4-pair monitor; the fifth passes through.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            exp_q.push_back(16'h1000 + 16'(p));
            cyc(1, 1, 0, 1, 1, 16'h1000 + 16'(p), 0, 16'h0, $sformatf("multi orig%0d", p),
                16'h1000 + 16'(p));
            exp_q.push_back((p < 4) ? 16'h1000 + 16'(p) : 16'h2000 + 16'(p));
            cyc(1, 1, 0, 1, 1, 16'h2000 + 16'(p), 0, 16'h0, $sformatf("multi dup%0d", p),
                (p < 4) ? 16'h1000 + 16'(p) : 16'h2000 + 16'(p));
        end
        check("multi ptr", 32'(dbg_ptr), 32'd4);
        check("multi in_count", dbg_in_count, 32'd10);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 0, 16'h0, 1, exp_q.pop_front(), $sformatf("multi rsp%0d", i), 16'h0);
            check($sformatf("multi done after rsp%0d", i), 32'(qed_done), (i >= 8) ? 32'd1 : 32'd0);
        end
        check("multi qed_check", 32'(qed_check), 32'd1);
        check("multi states", 32'(dbg_pair_state), 32'hFF);

        // flush and clk_en=0 both suppress the write; the next accepted write is the dup.
        do_reset();
        cyc(1, 1, 0, 1, 1, 16'h0A0A, 0, 16'h0, "fl orig", 16'h0A0A);
        cyc(1, 1, 1, 1, 1, 16'h1111, 0, 16'h0, "fl flush", 16'h1111);
        check("fl flush in_count", dbg_in_count, 32'd1);
        check("fl flush ptr", 32'(dbg_ptr), 32'd0);
        cyc(1, 0, 0, 1, 1, 16'h2222, 1, 16'h0A0A, "fl gated", 16'h2222);
        check("fl gated in_count", dbg_in_count, 32'd1);
        check("fl gated out_count", dbg_out_count, 32'd0);
        check("fl gated state", 32'(dbg_pair_state), 32'h01);
        cyc(1, 1, 0, 1, 1, 16'h3333, 0, 16'h0, "fl dup", 16'h0A0A);
        check("fl dup in_count", dbg_in_count, 32'd2);
        check("fl dup ptr", 32'(dbg_ptr), 32'd1);
        cyc(1, 1, 0, 0, 0, 16'h0, 1, 16'h0A0A, "fl rsp0", 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0, 1, 16'h0A0A, "fl rsp1", 16'h0);
        check("fl done early", 32'(qed_done), 32'd0);
        cyc(1, 1, 0, 0, 0, 16'h0, 0, 16'h0, "fl idle", 16'h0);
        check("fl done", 32'(qed_done), 32'd1);
        check("fl qed_check", 32'(qed_check), 32'd1);

        // Saturation on the 4-bit counter build.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_in(1, 1, 0, 1, 0, 16'(i), 0, 16'h0);
            tick();
        end
        check("sat in_count 14", 32'(s_in_count), 32'hE);
        set_in(1, 1, 0, 1, 0, 16'h00AA, 0, 16'h0);
        tick();
        check("sat in_count 15", 32'(s_in_count), 32'hF);
        set_in(1, 1, 0, 1, 1, 16'h4321, 0, 16'h0);
        #3;
        check("sat dout", 32'(s_data_out), 32'h4321);
        tick();
        check("sat hold", 32'(s_in_count), 32'hF);
        check("sat no issue ptr", 32'(s_ptr), 32'd0);
        check("sat no issue state", 32'(s_pair_state), 32'h00);

        // Reset mid-pair, with clk_en low during reset, then a fresh pair.
        do_reset();
        cyc(1, 1, 0, 1, 1, 16'h5A5A, 0, 16'h0, "mr orig", 16'h5A5A);
        check("mr state orig", 32'(dbg_pair_state), 32'h01);
        set_in(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        tick();
        check("mr in_count", dbg_in_count, 32'd0);
        check("mr ptr", 32'(dbg_ptr), 32'd0);
        check("mr state", 32'(dbg_pair_state), 32'h00);
        check("mr done", 32'(qed_done), 32'd0);
        check("mr check", 32'(qed_check), 32'd1);
        cyc(1, 1, 0, 1, 1, 16'h7777, 0, 16'h0, "mr new orig", 16'h7777);
        cyc(1, 1, 0, 1, 1, 16'h0000, 0, 16'h0, "mr new dup", 16'h7777);
        cyc(1, 1, 0, 0, 0, 16'h0, 1, 16'h7777, "mr rsp0", 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0, 1, 16'h7777, "mr rsp1", 16'h0);
        check("mr done early", 32'(qed_done), 32'd0);
        cyc(1, 1, 0, 0, 0, 16'h0, 0, 16'h0, "mr idle", 16'h0);
        check("mr done final", 32'(qed_done), 32'd1);
        check("mr check final", 32'(qed_check), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
